subtree_fanin_collector: RTL
============================

SUBTREE_FANIN_COLLECTOR -- requirements
Module: subtree_fanin_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width per channel.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  5  per-child beat valid (bit i = child inst_i).
REQ-006 SHALL have port in_data  input  5*DATA_W  per-child payload, child i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port in_ready  output  5  per-child accept; at most one bit set per cycle.
REQ-008 SHALL have port out_valid  output  1  head entry present.
REQ-009 SHALL have port out_data  output  DATA_W  head payload.
REQ-010 SHALL have port out_src  output  3  source child index (0..4) of head entry.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port fill  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Beat transfers on a channel when in_valid[i] and in_ready[i] are high on the same edge; the output transfers when out_valid and out_ready are high on the same edge.
REQ-014 in_ready SHALL be one-hot grant from a round-robin arbiter when fill < FIFO_DEPTH, else all zero; in_ready[i] SHALL never be set while in_valid[i] is low.
REQ-015 Arbiter priority SHALL start at the child after the last granted child, wrapping 4->0; after reset the last granted child is 4, so child 0 has highest priority.
REQ-016 Priority pointer SHALL advance only on a completed input transfer.
REQ-017 Accepted beat SHALL appear at out_valid/out_data/out_src on the cycle after acceptance when FIFO was empty (1-cycle latency); ordering SHALL be strict FIFO.
REQ-018 Full: no grant when fill == FIFO_DEPTH, even if out_ready is high that cycle (no pass-through).
REQ-019 Simultaneous push and pop: fill unchanged; both pointers advance.
REQ-020 Empty: out_valid low; out_data/out_src hold last-read values and are don't-care.
REQ-021 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 in_valid deassertion without transfer is legal; no input-side data-stability check is imposed.

Reset
REQ-023 On rst_n low, asynchronously: fill=0, out_valid=0, in_ready=0, pointers=0, arbiter last-grant=4, stats counters=0.
REQ-024 Reset mid-operation SHALL discard all buffered entries; no beat accepted in the reset cycle.
REQ-025 FIFO storage array SHALL not require reset.

Configuration
REQ-026 Macro SUBTREE_FANIN_STATS_EN, when defined, SHALL add output stat_cnt (5*16 bits), one 16-bit saturating counter of accepted beats per child, saturating at 16'hFFFF.
REQ-027 Without SUBTREE_FANIN_STATS_EN the port and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package subtree_fanin_pkg SHALL hold NUM_CHILD=5, SRC_W=3, STAT_W=16, and typedef src_idx_t.
REQ-029 Arbiter SHALL be a sub-module rr_arbiter5 (request 5, advance strobe, one-hot grant, encoded index); FIFO inline in top.

Verification
REQ-030 Reset then in_valid=5'b00001, data 8'hA5, out_ready=1 -> in_ready=5'b00001 cycle 0; out_valid=1, out_data=8'hA5, out_src=0 cycle 1.
REQ-031 in_valid=5'b11111 held, data_i=8'h10+i, out_ready=1 -> grants 0,1,2,3,4,0 in consecutive cycles; out_src sequence 0,1,2,3,4.
REQ-032 out_ready=0, in_valid=5'b00100 for 6 cycles -> 4 accepts, fill=4, in_ready=0 thereafter; one out_ready=1 pulse -> fill=3 that cycle end, grant resumes next cycle.
REQ-033 fill=2, push and pop same cycle -> fill stays 2, output order preserved.
REQ-034 rst_n low for 1 cycle while fill=3 -> out_valid=0, fill=0 immediately; next grant goes to child 0 if requesting.
REQ-035 With SUBTREE_FANIN_STATS_EN: 70000 beats from child 2 -> stat_cnt child 2 = 16'hFFFF, others 0.

Source files
------------

// File: rtl/subtree_fanin_pkg.sv
// Shared constants and types for the five-child fan-in collector.
package subtree_fanin_pkg;

    localparam int NUM_CHILD = 5;
    localparam int SRC_W     = 3;
    localparam int STAT_W    = 16;

    typedef logic [SRC_W-1:0] src_idx_t;

    // Child index 'step' positions after 'base', wrapping modulo NUM_CHILD.
    function automatic src_idx_t rr_next(input src_idx_t base, input int unsigned step);
        int unsigned s;
        s = int'(base) + step;
        return src_idx_t'(s % NUM_CHILD);
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter: searches from the child after the last grant,
// and only moves its pointer when the caller reports a completed transfer.
module rr_arbiter5
    import subtree_fanin_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CHILD-1:0] req,
    input  logic                 advance,
    output logic [NUM_CHILD-1:0] grant,
    output src_idx_t             grant_idx
);

    src_idx_t last_q;

    always_comb begin
        src_idx_t cand;
        logic     found;
        grant     = '0;
        grant_idx = last_q;
        found     = 1'b0;
        cand      = last_q;
        for (int k = 1; k <= NUM_CHILD; k++) begin
            cand = rr_next(last_q, k);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

    // Reset to the last child so child 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= src_idx_t'(NUM_CHILD - 1);
        else if (advance)
            last_q <= grant_idx;
    end

endmodule

// File: rtl/subtree_fanin_collector.sv
// Merges five child streams into one FIFO-buffered output, tagging each beat
// with its source. Optional per-child beat counters: SUBTREE_FANIN_STATS_EN.
module subtree_fanin_collector
    import subtree_fanin_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CHILD-1:0]          in_valid,
    input  logic [NUM_CHILD*DATA_W-1:0]   in_data,
    output logic [NUM_CHILD-1:0]          in_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [SRC_W-1:0]              out_src,
    input  logic                          out_ready,
`ifdef SUBTREE_FANIN_STATS_EN
    output logic [NUM_CHILD*STAT_W-1:0]   stat_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        src_idx_t          src;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                full, push, pop;
    logic [NUM_CHILD-1:0] req, grant;
    src_idx_t            grant_idx;
    logic [DATA_W-1:0]   push_data;

    // Full blocks every grant, even when the head is popped this same cycle.
    assign full = (fill == (AW+1)'(FIFO_DEPTH));
    assign req  = in_valid & {NUM_CHILD{~full & rst_n}};

    rr_arbiter5 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready = grant;
    assign push     = |grant;
    assign pop      = out_valid & out_ready;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_CHILD; i++)
            if (grant[i]) push_data = in_data[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{src: grant_idx, data: push_data};
    end

    assign out_valid = (fill != '0);
    assign out_data  = mem[rd_ptr].data;
    assign out_src   = mem[rd_ptr].src;

`ifdef SUBTREE_FANIN_STATS_EN
    for (genvar c = 0; c < NUM_CHILD; c++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (grant[c] && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
        assign stat_cnt[c*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule
